// File: rtl/open_drain_rx_if.sv
// Bus bundle for open_drain_rx: raw open-drain line in, filtered level,
// edge pulses and low-pulse width measurement out.
// The receiver drives the slave side; the line/consumer side is the master.
interface open_drain_rx_if #(
    parameter int WIDTH_BITS = 8
);
    logic                  data;
    logic                  ready;
    logic                  level;
    logic                  fall;
    logic                  rise;
    logic [WIDTH_BITS-1:0] width;
    logic                  valid;
    logic                  overrun;
    logic                  stuck;

    modport master (
        output data, ready,
        input  level, fall, rise, width, valid, overrun, stuck
    );

    modport slave (
        input  data, ready,
        output level, fall, rise, width, valid, overrun, stuck
    );
endinterface

// File: rtl/open_drain_rx.sv
// open_drain_rx: synchronizes and glitch-filters a raw open-drain line,
// flags filtered edges, and measures each low pulse in clock cycles with a
// valid/ready result register (one-deep, overrun flagged on drop).
// Optional macro OPEN_DRAIN_RX_STUCK_DETECT_EN: adds the stuck-low flag,
// set when the width counter saturates and cleared on the next filtered rise.
//
// Measurement FSM states:
//   state   | meaning
//   ST_IDLE | filtered line high, no pulse being timed
//   ST_LOW  | filtered line low, width counter running
module open_drain_rx #(
    parameter int FILTER_CYCLES = 3,
    parameter int WIDTH_BITS    = 8
) (
    input  logic           clk,
    input  logic           rst,
    open_drain_rx_if.slave bus
);

    if (FILTER_CYCLES < 1 || FILTER_CYCLES > 15) begin : g_bad_filter
        $error("open_drain_rx: FILTER_CYCLES must be in 1..15");
    end
    if (WIDTH_BITS < 4 || WIDTH_BITS > 16) begin : g_bad_width
        $error("open_drain_rx: WIDTH_BITS must be in 4..16");
    end

    // Toggle fires on the cycle the count would reach FILTER_CYCLES.
    localparam logic [3:0]            FILT_LAST = 4'(FILTER_CYCLES - 1);
    localparam logic [WIDTH_BITS-1:0] WIDTH_MAX = '1;
    localparam logic [WIDTH_BITS-1:0] WIDTH_ONE = WIDTH_BITS'(1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOW  = 1'b1
    } state_t;

    logic                  sync_meta;
    logic                  sync_q;
    logic [3:0]            flt_cnt;
    logic                  level_q;
    logic                  fall_q;
    logic                  rise_q;
    state_t                state_q;
    logic [WIDTH_BITS-1:0] wcnt_q;
    logic [WIDTH_BITS-1:0] width_q;
    logic                  valid_q;
    logic                  overrun_q;

    logic                  flt_diff;
    logic                  flt_hit;
    logic                  rise_evt;
    logic                  accept;

    assign flt_diff = sync_q ^ level_q;
    assign flt_hit  = flt_diff && (flt_cnt == FILT_LAST);
    assign rise_evt = flt_hit && sync_q;
    assign accept   = valid_q && bus.ready;

    // Two-flop synchronizer; idles at the released (pulled-up) level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta <= 1'b1;
            sync_q    <= 1'b1;
        end else begin
            sync_meta <= bus.data;
            sync_q    <= sync_meta;
        end
    end

    // Persistence filter: a new level must hold FILTER_CYCLES cycles in a row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flt_cnt <= 4'd0;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            fall_q <= 1'b0;
            rise_q <= 1'b0;
            if (!flt_diff) begin
                flt_cnt <= 4'd0;
            end else if (flt_hit) begin
                flt_cnt <= 4'd0;
                level_q <= sync_q;
                fall_q  <= ~sync_q;
                rise_q  <= sync_q;
            end else begin
                flt_cnt <= flt_cnt + 4'd1;
            end
        end
    end

    // Low-pulse timer and one-deep result register with valid/ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            wcnt_q    <= '0;
            width_q   <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (accept) begin
                valid_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (!level_q) begin
                        state_q <= ST_LOW;
                        wcnt_q  <= WIDTH_ONE;
                    end
                end
                ST_LOW: begin
                    if (!level_q) begin
                        if (wcnt_q != WIDTH_MAX) begin
                            wcnt_q <= wcnt_q + WIDTH_ONE;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                        // A result accepted this cycle frees the register.
                        if (!valid_q || accept) begin
                            width_q <= wcnt_q;
                            valid_q <= 1'b1;
                        end else begin
                            overrun_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef OPEN_DRAIN_RX_STUCK_DETECT_EN
    localparam logic [WIDTH_BITS-1:0] WIDTH_PRE_SAT = WIDTH_MAX - WIDTH_ONE;

    logic stuck_q;
    logic stuck_set;

    assign stuck_set = (state_q == ST_LOW) && !level_q && (wcnt_q == WIDTH_PRE_SAT);

    // Stuck-low flag: raised with counter saturation, dropped with the rise pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stuck_q <= 1'b0;
        end else if (rise_evt) begin
            stuck_q <= 1'b0;
        end else if (stuck_set) begin
            stuck_q <= 1'b1;
        end
    end

    assign bus.stuck = stuck_q;
`else
    assign bus.stuck = 1'b0;
`endif

    assign bus.level   = level_q;
    assign bus.fall    = fall_q;
    assign bus.rise    = rise_q;
    assign bus.width   = width_q;
    assign bus.valid   = valid_q;
    assign bus.overrun = overrun_q;

endmodule
